// File: rtl/selector41_rr_scheduler.sv
// selector41_rr_scheduler - round-robin, time-sliced owner of a 4:1 selector and its registered output bus.
module selector41_rr_scheduler #(
  parameter int WIDTH = 4,
  parameter int SLOT  = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [3:0]       iReq,
  input  logic [WIDTH-1:0] iC0,
  input  logic [WIDTH-1:0] iC1,
  input  logic [WIDTH-1:0] iC2,
  input  logic [WIDTH-1:0] iC3,
  output logic [3:0]       oGnt,
  output logic             oS1,
  output logic             oS0,
  output logic [WIDTH-1:0] oZ,
  output logic             oValid
);

  localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     ptr, ptr_n;
  logic [1:0]     sel, sel_n;
  logic [3:0]     gnt, gnt_n;
  logic [2:0]     pick;
  logic [WIDTH-1:0] mux;

  // Returns {hit, index}; scanning downward lets the lowest offset from start win.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    pick    = 3'b000;
    case (state)
      IDLE: begin
        pick = rr_pick(iReq, ptr);
        if (pick[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << pick[1:0];
          sel_n   = pick[1:0];
          cnt_n   = '0;
        end
      end
      GRANT: begin
        cnt_n = cnt + 1'b1;
        if (!iReq[sel] || cnt == CW'(SLOT - 1)) begin
          // Search restarts past the owner, so the owner itself is checked last.
          ptr_n = sel + 2'd1;
          pick  = rr_pick(iReq, sel + 2'd1);
          cnt_n = '0;
          if (pick[2]) begin
            gnt_n = 4'b0001 << pick[1:0];
            sel_n = pick[1:0];
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
    end
  end

  always_comb begin
    case (sel)
      2'd0:    mux = iC0;
      2'd1:    mux = iC1;
      2'd2:    mux = iC2;
      default: mux = iC3;
    endcase
  end

  // Data path follows the registered select, so it trails the grant by one edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oZ     <= '0;
      oValid <= 1'b0;
    end else begin
      oZ     <= mux;
      oValid <= (gnt != 4'b0000);
    end
  end

  assign oGnt = gnt;
  assign oS1  = sel[1];
  assign oS0  = sel[0];

endmodule

// File: tb/tb_selector41_rr_scheduler.sv
// tb_selector41_rr_scheduler - directed checks of grant order, slot length, release and data latency.
module tb_selector41_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] c0, c1, c2, c3;
  logic [3:0] gnt;
  logic       s1, s0;
  logic [3:0] z;
  logic       valid;

  int checks = 0;
  int errors = 0;

  logic [3:0] data [4];
  int         own;
  int         prev_own;

  selector41_rr_scheduler #(.WIDTH(4), .SLOT(4)) dut (
    .iClk(clk), .iRst_n(rst_n), .iReq(req),
    .iC0(c0), .iC1(c1), .iC2(c2), .iC3(c3),
    .oGnt(gnt), .oS1(s1), .oS0(s0), .oZ(z), .oValid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    c0 = 4'b0000; c1 = 4'b0011; c2 = 4'b1100; c3 = 4'b1111;
    data[0] = c0; data[1] = c1; data[2] = c2; data[3] = c3;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    chk("reset_gnt", 8'(gnt), 8'h0);
    chk("reset_sel", 8'({s1, s0}), 8'h0);
    chk("reset_z", 8'(z), 8'h0);
    chk("reset_valid", 8'(valid), 8'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 8'(gnt), 8'h0);

    // Sole requester 2, then all requests drop
    req = 4'b0100;
    tick();
    chk("s2_gnt_e1", 8'(gnt), 8'h4);
    chk("s2_sel_e1", 8'({s1, s0}), 8'h2);
    chk("s2_valid_e1", 8'(valid), 8'h0);
    tick();
    chk("s2_z_e2", 8'(z), 8'hC);
    chk("s2_valid_e2", 8'(valid), 8'h1);
    tick();
    tick();
    chk("s2_gnt_e4", 8'(gnt), 8'h4);
    tick();
    chk("s2_regrant_e5", 8'(gnt), 8'h4);
    chk("s2_regrant_valid_e5", 8'(valid), 8'h1);
    req = 4'b0000;
    tick();
    chk("drop_gnt", 8'(gnt), 8'h0);
    chk("drop_valid_still", 8'(valid), 8'h1);
    chk("drop_sel_hold", 8'({s1, s0}), 8'h2);
    tick();
    chk("drop_valid_low", 8'(valid), 8'h0);
    chk("drop_idle_gnt", 8'(gnt), 8'h0);

    // All four request: 0,1,2,3,0 with 4-cycle slots
    do_reset();
    req = 4'b1111;
    prev_own = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      own = ((k - 1) / 4) % 4;
      chk($sformatf("rr_gnt_%0d", k), 8'(gnt), 8'(4'b0001 << own));
      chk($sformatf("rr_sel_%0d", k), 8'({s1, s0}), 8'(own));
      if (k >= 2) begin
        chk($sformatf("rr_z_%0d", k), 8'(z), 8'(data[prev_own]));
        chk($sformatf("rr_valid_%0d", k), 8'(valid), 8'h1);
      end
      prev_own = own;
    end

    // Asynchronous reset mid-grant, observed before the next edge
    rst_n = 1'b0;
    #2;
    chk("async_gnt", 8'(gnt), 8'h0);
    chk("async_sel", 8'({s1, s0}), 8'h0);
    chk("async_z", 8'(z), 8'h0);
    chk("async_valid", 8'(valid), 8'h0);
    tick();
    rst_n = 1'b1;

    // Owner 1 drops early while 3 waits
    req = 4'b0010;
    tick();
    chk("early_gnt1", 8'(gnt), 8'h2);
    req = 4'b1010;
    tick();
    chk("early_no_preempt", 8'(gnt), 8'h2);
    req = 4'b1000;
    tick();
    chk("early_gnt3", 8'(gnt), 8'h8);
    chk("early_sel3", 8'({s1, s0}), 8'h3);
    chk("early_z_prev", 8'(z), 8'h3);
    tick();
    chk("early_z3", 8'(z), 8'hF);
    chk("early_valid3", 8'(valid), 8'h1);

    // Owner 0 at slot expiry with 1011 pending -> 1
    do_reset();
    req = 4'b0001;
    tick();
    chk("exp_gnt0", 8'(gnt), 8'h1);
    req = 4'b1011;
    tick();
    tick();
    tick();
    chk("exp_hold0", 8'(gnt), 8'h1);
    tick();
    chk("exp_next1", 8'(gnt), 8'h2);
    chk("exp_sel1", 8'({s1, s0}), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
